// File: rtl/sparse_block_scheduler.sv
// Sparse block scheduler: consumes block descriptors, skips all-zero blocks
// and sequences weight load, activation compute and array drain per block.
module sparse_block_scheduler #(
  parameter int N_ROWS = 8,
  parameter int N_COLS = 8,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_k_len,
  output logic              busy,
  output logic              done,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic              desc_zero,
  input  logic              desc_last,
  input  logic [ADDR_W-1:0] desc_wgt_addr,
  input  logic [ADDR_W-1:0] desc_act_addr,
  output logic              wgt_rd_en,
  output logic [ADDR_W-1:0] wgt_rd_addr,
  output logic              act_rd_en,
  output logic [ADDR_W-1:0] act_rd_addr,
  output logic              act_flush,
  output logic              load_weight,
  output logic              block_valid,
  output logic [CNT_W-1:0]  skip_count
);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, COMPUTE, DRAIN, DONE
  } state_t;

  localparam logic [7:0] LOAD_END  = 8'(N_ROWS - 1);
  localparam logic [7:0] DRAIN_END = 8'(N_COLS - 2);
  localparam bit         HAS_DRAIN = (N_COLS > 1);

  state_t     state;
  logic [7:0] k_len;
  logic [7:0] cnt;
  logic       last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_len       <= '0;
      cnt         <= '0;
      last        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      desc_ready  <= 1'b0;
      wgt_rd_en   <= 1'b0;
      wgt_rd_addr <= '0;
      act_rd_en   <= 1'b0;
      act_rd_addr <= '0;
      act_flush   <= 1'b0;
      load_weight <= 1'b0;
      block_valid <= 1'b0;
      skip_count  <= '0;
    end else begin
      // Array-side strobes track the buffers' one-cycle read latency
      done        <= 1'b0;
      load_weight <= wgt_rd_en;
      block_valid <= act_rd_en | act_flush;
      unique case (state)
        IDLE: begin
          if (start) begin
            k_len      <= (cfg_k_len == 8'd0) ? 8'd1 : cfg_k_len;
            skip_count <= '0;
            busy       <= 1'b1;
            desc_ready <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (desc_valid && desc_ready) begin
            if (desc_zero) begin
              if (skip_count != '1)
                skip_count <= skip_count + CNT_W'(1);
              if (desc_last) begin
                desc_ready <= 1'b0;
                done       <= 1'b1;
                state      <= DONE;
              end
            end else begin
              last        <= desc_last;
              wgt_rd_addr <= desc_wgt_addr;
              act_rd_addr <= desc_act_addr;
              desc_ready  <= 1'b0;
              wgt_rd_en   <= 1'b1;
              cnt         <= '0;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          if (cnt == LOAD_END) begin
            wgt_rd_en <= 1'b0;
            act_rd_en <= 1'b1;
            cnt       <= '0;
            state     <= COMPUTE;
          end else begin
            cnt         <= cnt + 8'd1;
            wgt_rd_addr <= wgt_rd_addr + ADDR_W'(1);
          end
        end
        COMPUTE: begin
          if (cnt == k_len - 8'd1) begin
            act_rd_en <= 1'b0;
            cnt       <= '0;
            if (HAS_DRAIN) begin
              act_flush <= 1'b1;
              state     <= DRAIN;
            end else if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              desc_ready <= 1'b1;
              state      <= FETCH;
            end
          end else begin
            cnt         <= cnt + 8'd1;
            act_rd_addr <= act_rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          if (cnt == DRAIN_END) begin
            act_flush <= 1'b0;
            cnt       <= '0;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              desc_ready <= 1'b1;
              state      <= FETCH;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sparse_block_scheduler.sv
// Bench for sparse_block_scheduler: randomized descriptor streams checked
// against a tile-level model of reads, strobe runs, skips and done timing.
module tb_sparse_block_scheduler;
  localparam int NR = 8;
  localparam int NC = 8;
  localparam int AW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, start, desc_valid, desc_zero, desc_last;
  logic [7:0]    cfg_k_len;
  logic [AW-1:0] desc_wgt_addr, desc_act_addr;
  logic          busy, done, desc_ready, wgt_rd_en, act_rd_en;
  logic          act_flush, load_weight, block_valid;
  logic [AW-1:0] wgt_rd_addr, act_rd_addr;
  logic [CW-1:0] skip_count;
  logic          s_busy, s_done, s_ready, s_wen, s_aen;
  logic          s_flush, s_lw, s_bv;
  logic [AW-1:0] s_waddr, s_aaddr;
  logic [1:0]    s_skip;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sparse_block_scheduler #(
    .N_ROWS(NR), .N_COLS(NC), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k_len(cfg_k_len),
    .busy(busy), .done(done), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_zero(desc_zero),
    .desc_last(desc_last), .desc_wgt_addr(desc_wgt_addr),
    .desc_act_addr(desc_act_addr), .wgt_rd_en(wgt_rd_en),
    .wgt_rd_addr(wgt_rd_addr), .act_rd_en(act_rd_en),
    .act_rd_addr(act_rd_addr), .act_flush(act_flush),
    .load_weight(load_weight), .block_valid(block_valid),
    .skip_count(skip_count)
  );

  // Narrow skip counter copy exposes saturation quickly
  sparse_block_scheduler #(
    .N_ROWS(NR), .N_COLS(NC), .ADDR_W(AW), .CNT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start), .cfg_k_len(cfg_k_len),
    .busy(s_busy), .done(s_done), .desc_valid(desc_valid),
    .desc_ready(s_ready), .desc_zero(desc_zero),
    .desc_last(desc_last), .desc_wgt_addr(desc_wgt_addr),
    .desc_act_addr(desc_act_addr), .wgt_rd_en(s_wen),
    .wgt_rd_addr(s_waddr), .act_rd_en(s_aen),
    .act_rd_addr(s_aaddr), .act_flush(s_flush),
    .load_weight(s_lw), .block_valid(s_bv),
    .skip_count(s_skip)
  );

  typedef struct {
    bit            zero;
    bit            last;
    logic [AW-1:0] w;
    logic [AW-1:0] a;
  } desc_t;

  desc_t descs[$];

  bit            mon_on = 1'b0;
  int            cyc = 0;
  logic [AW-1:0] wgt_q[$];
  logic [AW-1:0] act_q[$];
  int            lw_runs[$];
  int            bv_runs[$];
  int            xfer_cyc[$];
  int            done_cyc[$];
  int            lw_run, bv_run, bad_lw, bad_bv, overlap, ready_bad;
  logic          p_wen = 1'b0;
  logic          p_aen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (wgt_rd_en) wgt_q.push_back(wgt_rd_addr);
      if (act_rd_en) act_q.push_back(act_rd_addr);
      if (load_weight !== p_wen) bad_lw++;
      if (block_valid !== p_aen) bad_bv++;
      if (load_weight && block_valid) overlap++;
      if (desc_ready && (wgt_rd_en || act_rd_en || act_flush || !busy))
        ready_bad++;
      if (act_rd_en && act_flush) ready_bad++;
      if (desc_valid && desc_ready) xfer_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (load_weight) lw_run++;
      else if (lw_run != 0) begin
        lw_runs.push_back(lw_run);
        lw_run = 0;
      end
      if (block_valid) bv_run++;
      else if (bv_run != 0) begin
        bv_runs.push_back(bv_run);
        bv_run = 0;
      end
    end
    p_wen = wgt_rd_en;
    p_aen = act_rd_en || act_flush;
  end

  task automatic mon_clear();
    wgt_q.delete(); act_q.delete();
    lw_runs.delete(); bv_runs.delete();
    xfer_cyc.delete(); done_cyc.delete();
    lw_run = 0; bv_run = 0; bad_lw = 0;
    bad_bv = 0; overlap = 0; ready_bad = 0;
  endtask

  task automatic add_desc(input bit z, input bit l,
                          input logic [AW-1:0] w,
                          input logic [AW-1:0] a);
    descs.push_back('{zero: z, last: l, w: w, a: a});
  endtask

  // Runs one tile from IDLE and checks it against the model
  task automatic test_tile(input string name, input logic [7:0] kcfg,
                           input int gap);
    int k, nz, nzero, idx, budget, exp_done, sat;
    bit xfer;
    logic [AW-1:0] ew[$];
    logic [AW-1:0] ea[$];
    k = (kcfg == 8'd0) ? 1 : int'(kcfg);
    nz = 0;
    nzero = 0;
    foreach (descs[i]) begin
      if (descs[i].zero) nzero++;
      else begin
        nz++;
        for (int r = 0; r < NR; r++) ew.push_back(AW'(descs[i].w + r));
        for (int r = 0; r < k; r++) ea.push_back(AW'(descs[i].a + r));
      end
    end
    sat = (nzero > 3) ? 3 : nzero;
    mon_clear();
    mon_on = 1'b1;
    cfg_k_len = kcfg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_k_len = 8'($urandom);
    idx = 0;
    budget = 0;
    while (idx < descs.size() && budget < 4000) begin
      desc_valid = ($urandom_range(99) >= gap);
      if (desc_valid) begin
        desc_zero = descs[idx].zero;
        desc_last = descs[idx].last;
        desc_wgt_addr = descs[idx].w;
        desc_act_addr = descs[idx].a;
      end else begin
        desc_zero = 1'($urandom);
        desc_last = 1'($urandom);
        desc_wgt_addr = AW'($urandom);
        desc_act_addr = AW'($urandom);
      end
      @(negedge clk);
      xfer = desc_valid && desc_ready;
      @(posedge clk); #1;
      budget++;
      if (xfer) idx++;
    end
    desc_valid = 1'b0;
    while (done_cyc.size() == 0 && budget < 4000) begin
      @(posedge clk); #1;
      budget++;
    end
    repeat (3) @(posedge clk);
    #1;
    mon_on = 1'b0;

    checks++;
    if (budget >= 4000) begin
      failures++;
      $display("FAIL %s timeout got=%0d cycles limit=4000", name, budget);
    end
    checks++;
    if (xfer_cyc.size() != descs.size()) begin
      failures++;
      $display("FAIL %s transfers got=%0d exp=%0d", name,
               xfer_cyc.size(), descs.size());
    end
    checks++;
    if (wgt_q.size() != ew.size()) begin
      failures++;
      $display("FAIL %s wgt_reads got=%0d exp=%0d", name,
               wgt_q.size(), ew.size());
    end else begin
      foreach (ew[i]) begin
        checks++;
        if (wgt_q[i] !== ew[i]) begin
          failures++;
          $display("FAIL %s wgt_addr[%0d] got=%h exp=%h", name, i,
                   wgt_q[i], ew[i]);
        end
      end
    end
    checks++;
    if (act_q.size() != ea.size()) begin
      failures++;
      $display("FAIL %s act_reads got=%0d exp=%0d", name,
               act_q.size(), ea.size());
    end else begin
      foreach (ea[i]) begin
        checks++;
        if (act_q[i] !== ea[i]) begin
          failures++;
          $display("FAIL %s act_addr[%0d] got=%h exp=%h", name, i,
                   act_q[i], ea[i]);
        end
      end
    end
    checks++;
    if (lw_runs.size() != nz) begin
      failures++;
      $display("FAIL %s lw_runs got=%0d exp=%0d", name, lw_runs.size(), nz);
    end
    foreach (lw_runs[i]) begin
      checks++;
      if (lw_runs[i] != NR) begin
        failures++;
        $display("FAIL %s lw_len[%0d] got=%0d exp=%0d", name, i,
                 lw_runs[i], NR);
      end
    end
    checks++;
    if (bv_runs.size() != nz) begin
      failures++;
      $display("FAIL %s bv_runs got=%0d exp=%0d", name, bv_runs.size(), nz);
    end
    foreach (bv_runs[i]) begin
      checks++;
      if (bv_runs[i] != k + NC - 1) begin
        failures++;
        $display("FAIL %s bv_len[%0d] got=%0d exp=%0d", name, i,
                 bv_runs[i], k + NC - 1);
      end
    end
    checks++;
    if (bad_lw != 0 || bad_bv != 0) begin
      failures++;
      $display("FAIL %s delay_rule got lw=%0d bv=%0d exp=0", name,
               bad_lw, bad_bv);
    end
    checks++;
    if (overlap != 0 || ready_bad != 0) begin
      failures++;
      $display("FAIL %s overlap got=%0d ready_bad=%0d exp=0", name,
               overlap, ready_bad);
    end
    checks++;
    if (done_cyc.size() != 1) begin
      failures++;
      $display("FAIL %s done_count got=%0d exp=1", name, done_cyc.size());
    end else if (xfer_cyc.size() > 0) begin
      exp_done = xfer_cyc[xfer_cyc.size()-1] +
                 (descs[descs.size()-1].zero ? 1 : NR + k + NC);
      checks++;
      if (done_cyc[0] != exp_done) begin
        failures++;
        $display("FAIL %s done_cycle got=%0d exp=%0d", name,
                 done_cyc[0], exp_done);
      end
    end
    checks++;
    if (skip_count !== CW'(nzero)) begin
      failures++;
      $display("FAIL %s skip_count got=%0d exp=%0d", name,
               skip_count, nzero);
    end
    checks++;
    if (s_skip !== 2'(sat)) begin
      failures++;
      $display("FAIL %s skip_sat got=%0d exp=%0d", name, s_skip, sat);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after got=%b exp=0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    desc_valid = 1'b1;
    desc_zero = 1'b0;
    desc_last = 1'b1;
    cfg_k_len = 8'd3;
    desc_wgt_addr = 10'h155;
    desc_act_addr = 10'h2AA;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, desc_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000", {busy, done, desc_ready});
    end
    checks++;
    if ({wgt_rd_en, act_rd_en, act_flush} !== 3'b000) begin
      failures++;
      $display("FAIL reset_rd got=%b exp=000",
               {wgt_rd_en, act_rd_en, act_flush});
    end
    checks++;
    if ({load_weight, block_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_array got=%b exp=00", {load_weight, block_valid});
    end
    checks++;
    if (skip_count !== '0 || wgt_rd_addr !== '0 || act_rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_regs got=%h/%h/%h exp=0", skip_count,
               wgt_rd_addr, act_rd_addr);
    end
    start = 1'b0;
    desc_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || desc_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%b%b exp=00", busy, desc_ready);
    end
  endtask

  task automatic test_single_block();
    descs.delete();
    add_desc(1'b0, 1'b1, 10'h010, 10'h020);
    test_tile("single_block", 8'd4, 0);
  endtask

  task automatic test_skip_two();
    descs.delete();
    add_desc(1'b1, 1'b0, AW'($urandom), AW'($urandom));
    add_desc(1'b1, 1'b0, AW'($urandom), AW'($urandom));
    add_desc(1'b0, 1'b1, AW'($urandom), AW'($urandom));
    test_tile("skip_two", 8'd3, 30);
  endtask

  task automatic test_zero_only();
    descs.delete();
    add_desc(1'b1, 1'b1, AW'($urandom), AW'($urandom));
    test_tile("zero_only", 8'd5, 0);
  endtask

  task automatic test_stall_k0();
    cfg_k_len = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    desc_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(negedge clk);
      checks++;
      if (desc_ready !== 1'b1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL stall_ready[%0d] got=%b%b exp=11", c,
                 desc_ready, busy);
      end
      checks++;
      if ({wgt_rd_en, act_rd_en, act_flush, load_weight,
           block_valid, done} !== 6'b0) begin
        failures++;
        $display("FAIL stall_quiet[%0d] got=%b exp=000000", c,
                 {wgt_rd_en, act_rd_en, act_flush, load_weight,
                  block_valid, done});
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    desc_valid = 1'b1;
    desc_zero = 1'b1;
    desc_last = 1'b1;
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || skip_count !== CW'(1)) begin
      failures++;
      $display("FAIL stall_done got=%b/%0d exp=1/1", done, skip_count);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle got=%b%b exp=00", busy, done);
    end
    descs.delete();
    add_desc(1'b0, 1'b1, AW'($urandom), AW'($urandom));
    test_tile("k_len_zero", 8'd0, 20);
  endtask

  task automatic test_wrap();
    descs.delete();
    add_desc(1'b0, 1'b1, 10'h3FE, 10'h3FD);
    test_tile("addr_wrap", 8'd6, 0);
  endtask

  task automatic test_back_to_back();
    descs.delete();
    add_desc(1'b0, 1'b0, AW'($urandom), AW'($urandom));
    add_desc(1'b0, 1'b0, AW'($urandom), AW'($urandom));
    add_desc(1'b1, 1'b0, AW'($urandom), AW'($urandom));
    add_desc(1'b0, 1'b1, AW'($urandom), AW'($urandom));
    test_tile("back_to_back", 8'd2, 0);
  endtask

  task automatic test_saturate();
    descs.delete();
    for (int i = 0; i < 5; i++)
      add_desc(1'b1, i == 4, AW'($urandom), AW'($urandom));
    test_tile("skip_saturate", 8'd1, 10);
  endtask

  task automatic test_reset_mid_load();
    int n, budget;
    cfg_k_len = 8'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    desc_valid = 1'b1;
    desc_zero = 1'b0;
    desc_last = 1'b1;
    desc_wgt_addr = AW'($urandom);
    desc_act_addr = AW'($urandom);
    n = 0;
    budget = 0;
    while (n < 4 && budget < 100) begin
      @(negedge clk);
      if (wgt_rd_en) n++;
      budget++;
    end
    checks++;
    if (n != 4 || load_weight !== 1'b1) begin
      failures++;
      $display("FAIL mid_load_reach got=%0d/%b exp=4/1", n, load_weight);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({load_weight, wgt_rd_en, busy} !== 3'b000) begin
      failures++;
      $display("FAIL mid_load_reset got=%b exp=000",
               {load_weight, wgt_rd_en, busy});
    end
    desc_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    descs.delete();
    add_desc(1'b0, 1'b1, AW'($urandom), AW'($urandom));
    test_tile("post_reset", 8'd3, 0);
  endtask

  task automatic test_random();
    int nd;
    for (int t = 0; t < 6; t++) begin
      descs.delete();
      nd = $urandom_range(1, 5);
      for (int i = 0; i < nd; i++)
        add_desc($urandom_range(99) < 40, i == nd - 1,
                 AW'($urandom), AW'($urandom));
      test_tile($sformatf("random%0d", t), 8'($urandom_range(0, 12)),
                $urandom_range(0, 50));
    end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_skip_two();
    test_zero_only();
    test_stall_k0();
    test_wrap();
    test_back_to_back();
    test_saturate();
    test_reset_mid_load();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
